// File: rtl/note_tone_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : note_tone_gen_if
//  Description : Signal bundle for the note tone generator. Carries the two
//                tone half-period inputs, the optional volume level and the
//                four Pmod I2S DAC pins.
//                  note_div_left/right : half-period in clk cycles (0/1 = mute)
//                  volume              : amplitude level 0..7 (VOLUME_CTRL_EN)
//                  audio_mclk/lrck/sck : DAC master, word-select, bit clocks
//                  audio_sdin          : DAC serial data, MSB first
//                master = tone source / DAC side, slave = generator.
//  Config      : VOLUME_CTRL_EN adds the volume signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface note_tone_gen_if;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
`ifdef VOLUME_CTRL_EN
    logic [2:0]  volume;
`endif
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;

`ifdef VOLUME_CTRL_EN
    modport master (
        output note_div_left, note_div_right, volume,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
    modport slave (
        input  note_div_left, note_div_right, volume,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
`else
    modport master (
        output note_div_left, note_div_right,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
    modport slave (
        input  note_div_left, note_div_right,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
`endif
endinterface
`default_nettype wire

// File: rtl/note_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : note_tone_gen
//  Description : Two independent square-wave tone channels serialised to a
//                Pmod I2S DAC. A 9-bit free-running divider provides
//                mclk = clk/4, sck = clk/16, lrck = clk/512. Channel samples
//                are latched into shadow registers once per 512-cycle frame
//                and shifted out MSB first, left word while lrck is low.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - note_tone_gen_if.slave (tone inputs, DAC pins)
//  Config      : VOLUME_CTRL_EN - amplitude = volume x 16'h1000 instead of
//                the fixed 16'h4000.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_tone_gen (
    input  wire logic      clk,
    input  wire logic      rst_n,
    note_tone_gen_if.slave bus
);

    localparam logic [21:0] DIV_SILENT_MAX = 22'd1;
    localparam logic [8:0]  DIV_LAST       = 9'h1FF;

    logic [21:0] cnt_l;
    logic [21:0] cnt_r;
    logic        sq_l;
    logic        sq_r;
    logic        silent_l;
    logic        silent_r;
    logic [15:0] amp;
    logic [15:0] neg_amp;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic [8:0]  div;
    logic [15:0] shadow_l;
    logic [15:0] shadow_r;
    logic [15:0] tx_word;
    logic [3:0]  bit_sel;

    assign silent_l = (bus.note_div_left  <= DIV_SILENT_MAX);
    assign silent_r = (bus.note_div_right <= DIV_SILENT_MAX);

    // Tone counters. The wrap uses >= so that shrinking note_div below the
    // running count wraps on the very next cycle instead of running on to
    // 2^22.
    always_ff @(posedge clk) begin
        if (!rst_n || silent_l) begin
            cnt_l <= '0;
            sq_l  <= 1'b0;
        end else if (cnt_l >= (bus.note_div_left - 22'd1)) begin
            cnt_l <= '0;
            sq_l  <= ~sq_l;
        end else begin
            cnt_l <= cnt_l + 22'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || silent_r) begin
            cnt_r <= '0;
            sq_r  <= 1'b0;
        end else if (cnt_r >= (bus.note_div_right - 22'd1)) begin
            cnt_r <= '0;
            sq_r  <= ~sq_r;
        end else begin
            cnt_r <= cnt_r + 22'd1;
        end
    end

`ifdef VOLUME_CTRL_EN
    assign amp = {1'b0, bus.volume, 12'h000};
`else
    assign amp = 16'h4000;
`endif
    assign neg_amp = 16'h0000 - amp;

    assign sample_l = silent_l ? 16'h0000 : (sq_l ? amp : neg_amp);
    assign sample_r = silent_r ? 16'h0000 : (sq_r ? amp : neg_amp);

    // Frame divider and shadow capture. Capturing on the last cycle of a
    // frame keeps both words constant for the whole following frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div      <= '0;
            shadow_l <= '0;
            shadow_r <= '0;
        end else begin
            div <= div + 9'd1;
            if (div == DIV_LAST) begin
                shadow_l <= sample_l;
                shadow_r <= sample_r;
            end
        end
    end

    // Bit index advances with div[7:4], i.e. on the sck falling edge, so each
    // bit is centred on the sck rising edge.
    assign tx_word = div[8] ? shadow_r : shadow_l;
    assign bit_sel = 4'hF - div[7:4];

    assign bus.audio_mclk = div[1];
    assign bus.audio_sck  = div[3];
    assign bus.audio_lrck = div[8];
    assign bus.audio_sdin = tx_word[bit_sel];

endmodule
`default_nettype wire
